// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the roadside sensor front end:
//   - svc_state_t : service FSM encodings (IDLE / WAITING / SERVING)
//   - default debounce and departure cycle counts
//   - is_one_hot3 : helper used by the light checker on {R, Y, G}
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        SVC_IDLE    = 2'd0,
        SVC_WAITING = 2'd1,
        SVC_SERVING = 2'd2
    } svc_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DEPART_CYCLES_DEF   = 8;

    // True when exactly one of the three aspect bits is lit.
    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// ---------------------------------------------------------------------------
// sensor_debouncer
// Two-flop synchroniser plus stability counter for the raw loop detector.
// The clean level only follows the synchronised input after it has differed
// from the current clean level for DEBOUNCE_CYCLES consecutive samples.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous, active-low reset
//   raw        : raw loop detector (asynchronous, may bounce)
//   clean      : debounced loop level
//   rise_pulse : one-cycle strobe on each rising edge of clean
// ---------------------------------------------------------------------------
module sensor_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic rise_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_clean;
    logic            r_clean_d;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= raw;
            r_s2      <= r_s1;
            r_clean_d <= r_clean;
            if (r_s2 != r_clean) begin
                // The edge that would bring the count to DEBOUNCE_CYCLES
                // commits the new level instead of storing the count.
                if (r_cnt == DB_LAST) begin
                    r_clean <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign clean      = r_clean;
    assign rise_pulse = r_clean & ~r_clean_d;

endmodule

// File: rtl/traffic_sensor_frontend.sv
// ---------------------------------------------------------------------------
// traffic_sensor_frontend
// Roadside end of the controller's sensor/lights interface. Debounces the EW
// inductive loop, counts waiting EW vehicles, drains one vehicle every
// DEPART_CYCLES cycles of EW green, requests service through `sensor`, and
// flags illegal light aspect combinations.
// Ports:
//   clk, rst                      : clock (rising) / sync active-low reset
//   loop_raw                      : raw EW loop detector
//   NS_Red/Yellow/Green           : NS aspects from the controller
//   EW_Red/Yellow/Green           : EW aspects from the controller
//   ovf_clr                       : single-cycle clear of queue_overflow
//   sensor                        : vehicle-waiting request (registered)
//   queue_count [CNT_W-1:0]       : vehicles waiting (registered, saturating)
//   queue_overflow                : sticky, arrival lost at saturation
//   light_fault                   : sticky until reset, illegal aspects seen
//   svc_state [1:0]               : 0 IDLE, 1 WAITING, 2 SERVING
// ---------------------------------------------------------------------------
module traffic_sensor_frontend
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DEPART_CYCLES   = DEPART_CYCLES_DEF,
    parameter int QUEUE_DEPTH     = 15,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic             NS_Red,
    input  logic             NS_Yellow,
    input  logic             NS_Green,
    input  logic             EW_Red,
    input  logic             EW_Yellow,
    input  logic             EW_Green,
    input  logic             ovf_clr,
    output logic             sensor,
    output logic [CNT_W-1:0] queue_count,
    output logic             queue_overflow,
    output logic             light_fault,
    output logic [1:0]       svc_state
);

    localparam int TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEPART_CYCLES - 1);
    localparam logic [CNT_W-1:0] Q_MAX    = CNT_W'(QUEUE_DEPTH);

    logic             w_clean;
    logic             w_rise;
    logic             w_arrive;
    logic             w_depart;
    logic             w_ovf_set;
    logic             w_illegal;
    logic [CNT_W-1:0] w_queue_next;

    logic [TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_queue;
    logic             r_sensor;
    logic             r_ovf;
    logic             r_fault;
    logic             r_chk_en;
    svc_state_t       r_state;

    sensor_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .raw        (loop_raw),
        .clean      (w_clean),
        .rise_pulse (w_rise)
    );

    // The rise strobe is only ever high while clean is high; qualifying it
    // with the level keeps the arrival tied to the debounced loop state.
    assign w_arrive = w_rise & w_clean;

    // Departure timer free-runs during EW green, even with an empty queue;
    // it only produces a departure when a vehicle is waiting.
    always_ff @(posedge clk) begin
        if (!rst || !EW_Green) begin
            r_tmr <= '0;
        end else if (r_tmr == TMR_LAST) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    assign w_depart = (r_tmr == TMR_LAST) & EW_Green & (r_queue != '0);

    // Simultaneous arrival and departure cancel out.
    always_comb begin
        w_queue_next = r_queue;
        w_ovf_set    = 1'b0;
        if (w_arrive && !w_depart) begin
            if (r_queue < Q_MAX) begin
                w_queue_next = r_queue + CNT_W'(1);
            end else begin
                w_ovf_set = 1'b1;
            end
        end else if (w_depart && !w_arrive) begin
            w_queue_next = r_queue - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_queue  <= '0;
            r_sensor <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_queue  <= w_queue_next;
            r_sensor <= (w_queue_next != '0);
            // A lost arrival outranks a clear landing on the same edge.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Service FSM: looks ahead at queue_next so it moves on the same edge
    // as queue_count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SVC_IDLE;
        end else if (w_queue_next == '0) begin
            r_state <= SVC_IDLE;
        end else if (EW_Green) begin
            r_state <= SVC_SERVING;
        end else begin
            r_state <= SVC_WAITING;
        end
    end

    // Light checker. r_chk_en masks the first edge after reset release so
    // that aspects still settling from the controller's own reset are ignored.
    assign w_illegal = (NS_Green & EW_Green)
                     | ~is_one_hot3({NS_Red, NS_Yellow, NS_Green})
                     | ~is_one_hot3({EW_Red, EW_Yellow, EW_Green});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chk_en <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_chk_en <= 1'b1;
            if (r_chk_en && w_illegal) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign sensor         = r_sensor;
    assign queue_count    = r_queue;
    assign queue_overflow = r_ovf;
    assign light_fault    = r_fault;
    assign svc_state      = r_state;

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// ---------------------------------------------------------------------------
// Self-checking bench for traffic_sensor_frontend at default parameters
// (DEBOUNCE_CYCLES=4, DEPART_CYCLES=8, QUEUE_DEPTH=15, CNT_W=4).
// Inputs change on the falling edge; outputs are checked on the falling edge
// following each rising edge.
// ---------------------------------------------------------------------------
module tb_traffic_sensor_frontend;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       loop_raw = 1'b0;
    logic       NS_Red = 1'b0, NS_Yellow = 1'b0, NS_Green = 1'b1;
    logic       EW_Red = 1'b1, EW_Yellow = 1'b0, EW_Green = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       sensor;
    logic [3:0] queue_count;
    logic       queue_overflow;
    logic       light_fault;
    logic [1:0] svc_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_SERV = 2'd2;

    traffic_sensor_frontend dut (
        .clk            (clk),
        .rst            (rst),
        .loop_raw       (loop_raw),
        .NS_Red         (NS_Red),
        .NS_Yellow      (NS_Yellow),
        .NS_Green       (NS_Green),
        .EW_Red         (EW_Red),
        .EW_Yellow      (EW_Yellow),
        .EW_Green       (EW_Green),
        .ovf_clr        (ovf_clr),
        .sensor         (sensor),
        .queue_count    (queue_count),
        .queue_overflow (queue_overflow),
        .light_fault    (light_fault),
        .svc_state      (svc_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       loop;
        logic       ewg;
        logic       clr;
        logic [3:0] cnt;
        logic       sen;
        logic [1:0] st;
        logic       ovf;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ns(input logic r, input logic y, input logic g);
        NS_Red = r; NS_Yellow = y; NS_Green = g;
    endtask

    task automatic set_ew(input logic r, input logic y, input logic g);
        EW_Red = r; EW_Yellow = y; EW_Green = g;
    endtask

    // ewg=1: NS red / EW green; ewg=0: NS green / EW red.
    task automatic set_lights(input logic ewg);
        if (ewg) begin
            set_ns(1'b1, 1'b0, 1'b0); set_ew(1'b0, 1'b0, 1'b1);
        end else begin
            set_ns(1'b0, 1'b0, 1'b1); set_ew(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] cnt, input logic sen,
                           input logic [1:0] st, input logic ovf, input logic flt);
        chk({tag, " count"},    32'(queue_count),    32'(cnt));
        chk({tag, " sensor"},   32'(sensor),         32'(sen));
        chk({tag, " state"},    32'(svc_state),      32'(st));
        chk({tag, " overflow"}, 32'(queue_overflow), 32'(ovf));
        chk({tag, " fault"},    32'(light_fault),    32'(flt));
    endtask

    // One clean vehicle with EW red: the count moves on the 7th edge after
    // the loop rise, then the loop is released and allowed to settle.
    task automatic add_vehicle(input string tag, input logic [3:0] exp_cnt, input logic exp_ovf);
        loop_raw = 1'b1;
        repeat (7) tick();
        chk({tag, " count"}, 32'(queue_count), 32'(exp_cnt));
        chk({tag, " ovf"},   32'(queue_overflow), 32'(exp_ovf));
        tick();
        loop_raw = 1'b0;
        repeat (8) tick();
        $display("vehicle %s: count=%0d ovf=%0d", tag, queue_count, queue_overflow);
    endtask

    function automatic vec_t mk(input logic loop, input logic ewg, input logic clr,
                                input logic [3:0] cnt, input logic sen,
                                input logic [1:0] st, input logic ovf);
        vec_t v;
        v.loop = loop; v.ewg = ewg; v.clr = clr;
        v.cnt = cnt; v.sen = sen; v.st = st; v.ovf = ovf;
        return v;
    endfunction

    initial begin
        logic [3:0] exp_cnt;

        // Single arrival: loop high for 8 edges, then low for 8 edges.
        tbl[0]  = mk(1, 0, 0, 0, 0, ST_IDLE, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, ST_IDLE, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, ST_IDLE, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, ST_IDLE, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, ST_IDLE, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, ST_IDLE, 0);
        tbl[6]  = mk(1, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[7]  = mk(1, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[9]  = mk(0, 0, 1, 1, 1, ST_WAIT, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[11] = mk(0, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[12] = mk(0, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[13] = mk(0, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[14] = mk(0, 0, 0, 1, 1, ST_WAIT, 0);
        tbl[15] = mk(0, 0, 0, 1, 1, ST_WAIT, 0);

        // ---------------- reset ----------------
        set_lights(1'b0);
        rst = 1'b0;
        repeat (10) tick();
        chk_all("reset", 4'd0, 1'b0, ST_IDLE, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // ---------------- glitch rejection ----------------
        for (int g = 0; g < 5; g++) begin
            loop_raw = 1'b1;
            repeat (3) tick();
            loop_raw = 1'b0;
            repeat (5) tick();
            chk($sformatf("glitch%0d count", g), 32'(queue_count), 32'd0);
            chk($sformatf("glitch%0d sensor", g), 32'(sensor), 32'd0);
        end
        $display("glitch burst x5: count=%0d sensor=%0d", queue_count, sensor);

        // ---------------- single arrival (table) ----------------
        for (int i = 0; i < 16; i++) begin
            loop_raw = tbl[i].loop;
            set_lights(tbl[i].ewg);
            ovf_clr  = tbl[i].clr;
            tick();
            chk($sformatf("tbl[%0d] count", i),  32'(queue_count),    32'(tbl[i].cnt));
            chk($sformatf("tbl[%0d] sensor", i), 32'(sensor),         32'(tbl[i].sen));
            chk($sformatf("tbl[%0d] state", i),  32'(svc_state),      32'(tbl[i].st));
            chk($sformatf("tbl[%0d] ovf", i),    32'(queue_overflow), 32'(tbl[i].ovf));
            $display("vec %0d: loop=%0d count=%0d sensor=%0d state=%0d",
                     i, tbl[i].loop, queue_count, sensor, svc_state);
        end
        ovf_clr = 1'b0;

        // ---------------- drain ----------------
        add_vehicle("q2", 4'd2, 1'b0);
        add_vehicle("q3", 4'd3, 1'b0);
        set_lights(1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_cnt = (k >= 24) ? 4'd0 : 4'(3 - k / 8);
            chk($sformatf("drain k=%0d count", k),  32'(queue_count), 32'(exp_cnt));
            chk($sformatf("drain k=%0d sensor", k), 32'(sensor), 32'(exp_cnt != 0));
            chk($sformatf("drain k=%0d state", k),  32'(svc_state),
                32'((exp_cnt != 0) ? ST_SERV : ST_IDLE));
        end
        $display("drain done: count=%0d state=%0d", queue_count, svc_state);
        set_lights(1'b0);
        tick();

        // ---------------- saturation / overflow ----------------
        for (int i = 1; i <= 16; i++) begin
            add_vehicle($sformatf("sat%0d", i), 4'((i > 15) ? 15 : i), 1'(i == 16));
        end
        chk_all("saturated", 4'd15, 1'b1, ST_WAIT, 1'b1, 1'b0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr clears", 32'(queue_overflow), 32'd0);
        loop_raw = 1'b1;
        repeat (6) tick();
        chk("pre-lost ovf", 32'(queue_overflow), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("set beats clear ovf", 32'(queue_overflow), 32'd1);
        chk("set beats clear count", 32'(queue_count), 32'd15);
        tick();
        loop_raw = 1'b0;
        repeat (8) tick();
        $display("overflow sequence: count=%0d ovf=%0d", queue_count, queue_overflow);

        // ---------------- simultaneous arrival/departure, mid-drain reset ----------------
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_all("re-reset", 4'd0, 1'b0, ST_IDLE, 1'b0, 1'b0);
        add_vehicle("s1", 4'd1, 1'b0);
        add_vehicle("s2", 4'd2, 1'b0);
        set_lights(1'b1);
        tick();
        loop_raw = 1'b1;
        for (int j = 2; j <= 10; j++) begin
            tick();
            chk($sformatf("simul edge%0d count", j), 32'(queue_count), 32'd2);
        end
        chk("simul state", 32'(svc_state), 32'(ST_SERV));
        $display("simultaneous arrive/depart: count=%0d", queue_count);
        rst = 1'b0;
        tick();
        chk_all("mid-drain reset", 4'd0, 1'b0, ST_IDLE, 1'b0, 1'b0);
        loop_raw = 1'b0;
        set_lights(1'b0);
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("queue discarded", 32'(queue_count), 32'd0);

        // ---------------- light fault: NS_Green & EW_Green ----------------
        repeat (3) tick();
        set_ns(1'b0, 1'b0, 1'b1);
        set_ew(1'b0, 1'b0, 1'b1);
        tick();
        chk("both green fault", 32'(light_fault), 32'd1);
        set_lights(1'b0);
        repeat (5) tick();
        chk("fault held", 32'(light_fault), 32'd1);
        chk("fault no queue effect", 32'(queue_count), 32'd0);
        chk("fault no sensor effect", 32'(sensor), 32'd0);
        $display("fault both-green: fault=%0d", light_fault);

        // ---------------- light fault: NS R+Y, first edge suppressed ----------------
        rst = 1'b0;
        set_ns(1'b1, 1'b1, 1'b0);
        set_ew(1'b1, 1'b0, 1'b0);
        tick();
        chk("RY reset fault", 32'(light_fault), 32'd0);
        rst = 1'b1;
        tick();
        chk("RY first edge suppressed", 32'(light_fault), 32'd0);
        tick();
        chk("RY fault set", 32'(light_fault), 32'd1);
        $display("fault NS red+yellow: fault=%0d", light_fault);

        // ---------------- long legal sequence ----------------
        rst = 1'b0;
        set_lights(1'b0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            case ((i / 10) % 6)
                0: begin set_ns(1'b0, 1'b0, 1'b1); set_ew(1'b1, 1'b0, 1'b0); end
                1: begin set_ns(1'b0, 1'b1, 1'b0); set_ew(1'b1, 1'b0, 1'b0); end
                2: begin set_ns(1'b1, 1'b0, 1'b0); set_ew(1'b1, 1'b0, 1'b0); end
                3: begin set_ns(1'b1, 1'b0, 1'b0); set_ew(1'b0, 1'b0, 1'b1); end
                4: begin set_ns(1'b1, 1'b0, 1'b0); set_ew(1'b0, 1'b1, 1'b0); end
                default: begin set_ns(1'b1, 1'b0, 1'b0); set_ew(1'b1, 1'b0, 1'b0); end
            endcase
            tick();
            if (i % 500 == 499) begin
                chk($sformatf("legal cycle %0d fault", i), 32'(light_fault), 32'd0);
            end
        end
        chk_all("legal end", 4'd0, 1'b0, ST_IDLE, 1'b0, 1'b0);
        $display("legal sequence 4000 cycles: fault=%0d", light_fault);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_frontend.md
Name: traffic_sensor_frontend

Overview:
Roadside end of the controller's sensor/lights interface. It takes the raw EW inductive-loop detector, synchronises and debounces it, and counts waiting EW vehicles. Queued vehicles are drained while the controller shows EW_Green, and `sensor` is driven back to the controller whenever the queue is non-empty. It also watches the six light outputs and flags any illegal aspect combination.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed before the clean loop level changes (≥1).
- DEPART_CYCLES, 8: EW_Green cycles per departing vehicle (≥1).
- QUEUE_DEPTH, 15: saturation value of the vehicle count (≤ 2^CNT_W − 1).
- CNT_W, 4: width of queue_count.

Ports:
- clk, input, 1: clock, rising-edge.
- rst, input, 1: synchronous, active-low reset.
- loop_raw, input, 1: raw loop detector, asynchronous to clk, may bounce.
- NS_Red, NS_Yellow, NS_Green, input, 1 each: NS aspects from the controller.
- EW_Red, EW_Yellow, EW_Green, input, 1 each: EW aspects from the controller.
- ovf_clr, input, 1: single-cycle clear of queue_overflow.
- sensor, output, 1: vehicle-waiting request to the controller, registered.
- queue_count, output, CNT_W: vehicles waiting, registered.
- queue_overflow, output, 1: sticky, arrival lost at saturation.
- light_fault, output, 1: sticky, illegal light combination seen.
- svc_state, output, 2: 0 = IDLE, 1 = WAITING, 2 = SERVING; 3 is never driven.

Behaviour:
- Reset: rst is synchronous and active-low; clock is clk. With rst = 0 at an edge, all of these clear:
  - sensor, queue_count, queue_overflow, light_fault = 0; svc_state = IDLE.
  - Sync flops, clean level, debounce counter and departure timer = 0.
  - Reset mid-operation discards the queue.
- Synchroniser: 2-flop on loop_raw (s1 → s2).
- Debounce:
  - Counter increments on each edge where s2 ≠ clean, and clears on any edge where s2 == clean.
  - When the counter reaches DEBOUNCE_CYCLES, clean takes s2 and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES samples never reach clean.
- Arrival: arrive = clean & ~clean_d, where clean_d is clean delayed one cycle.
  - One arrival per clean rising edge; the falling edge has no effect.
  - A loop_raw rise held stable, first sampled at edge 1, updates queue_count at edge 2 + DEBOUNCE_CYCLES + 1 (edge 7 at defaults).
- Departure timer:
  - Counts 0..DEPART_CYCLES−1 while EW_Green = 1.
  - Clears when EW_Green = 0 or rst.
  - depart = (timer == DEPART_CYCLES−1) & EW_Green & (queue_count ≠ 0).
  - The timer wraps and keeps running while queue_count = 0, but no departure occurs then.
- Queue update (queue_next):
  - arrive & ~depart: +1 if queue_count < QUEUE_DEPTH; otherwise unchanged and queue_overflow set.
  - depart & ~arrive: −1.
  - Both or neither: unchanged.
  - Never wraps or underflows.
- queue_overflow: cleared by ovf_clr. If the set and the clear land on the same edge, set wins.
- sensor: updates on the same edge as queue_count; sensor ← (queue_next ≠ 0).
- Service FSM, registered, evaluated on queue_next and current EW_Green:
  - IDLE → WAITING when queue_next ≠ 0 and EW_Green = 0.
  - IDLE or WAITING → SERVING when queue_next ≠ 0 and EW_Green = 1.
  - SERVING → WAITING when EW_Green = 0 and queue_next ≠ 0.
  - Any state → IDLE when queue_next = 0.
- Light checker: a sample is illegal if either of these holds:
  - NS_Green & EW_Green.
  - Either direction's {R, Y, G} is not exactly one-hot.
  - Checking is suppressed on the first edge after rst deasserts.
  - light_fault is set on the edge that samples an illegal combination and stays set until rst.
  - The checker never alters queue or sensor behaviour.

Decomposition:
- Shared package traffic_pkg holds:
  - svc_state encodings SVC_IDLE, SVC_WAITING, SVC_SERVING.
  - Default values of DEBOUNCE_CYCLES and DEPART_CYCLES.
- One sub-module: sensor_debouncer, containing the synchroniser, debounce counter and clean/arrive generation. Parameter: DEBOUNCE_CYCLES. Ports: clk, rst, raw, clean, rise_pulse.
- Queue, departure timer, FSM and light checker stay in the top module.

Test Plan:
- Reset and single arrival: hold rst = 0 for 10 cycles, then release with lights NS_Green/EW_Red; raise loop_raw and hold → queue_count = 1, sensor = 1, svc_state = WAITING exactly 7 edges after the first sampling edge; no change before that edge.
- Glitch rejection: loop_raw high for 3 cycles then low, repeated 5 times → queue_count stays 0, sensor stays 0.
- Drain: 3 vehicles queued, then drive EW_Green (NS_Red) for 30 cycles → queue_count 3 → 2 → 1 → 0 at EW_Green cycles 8, 16, 24; svc_state SERVING → IDLE; sensor falls on the edge where the count reaches 0.
- Saturation and overflow clear: 16 clean arrivals with EW_Red → queue_count = 15, queue_overflow = 1; pulse ovf_clr → 0; an ovf_clr pulse coinciding with a lost arrival leaves queue_overflow = 1.
- Simultaneous events: time an arrival onto the departure edge with queue_count = 2 → count stays 2; then apply rst = 0 mid-drain → all outputs 0 on the next edge.
- Light fault: NS_Green = EW_Green = 1 for one cycle → light_fault = 1 and held; a separate run with NS = {R, Y} = 1,1 also sets it; a clean 4000-cycle legal sequence keeps it 0.
